// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the DSO host link.
// Synchronizes the asynchronous RX line, qualifies the start bit at half a bit
// period, samples data and stop bits at mid-bit and presents one byte at a time
// with a ready flag, a one-cycle frame-error pulse and a sticky overrun flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 44
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   baud_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_data_q;
  logic            rdy_q;
  logic            frame_err_q;
  logic            overrun_q;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  logic rx_m_q;
  logic rx_s_q;
  logic rx_p_q;
  logic fall;

  assign fall = ~rx_s_q & rx_p_q;

  // Synchronizer chain; idles high so reset never looks like a start edge.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= RX;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // Receive FSM with its datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: defaults first, so frame_err_q is a single-cycle pulse and every
      // path through the case leaves each register with a defined next value.
      frame_err_q <= 1'b0;
      baud_cnt_q  <= baud_cnt_q + 1'b1;

      // Consumer acknowledge; a good stop bit below overrides this on the same edge.
      if (clr_rdy && rdy_q) begin
        rdy_q     <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q    <= START;
            baud_cnt_q <= '0;
          end
        end

        START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            // A high line at mid start bit was a glitch: drop back silently.
            state_q    <= rx_s_q ? IDLE : DATA;
          end
        end

        DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s_q, shift_q[7:1]};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end

        STOP: begin
          if (baud_cnt_q == BIT_LAST) begin
            // Returning to IDLE mid stop bit lets a back-to-back start edge be caught.
            baud_cnt_q <= '0;
            state_q    <= IDLE;
            if (rx_s_q) begin
              rx_data_q <= shift_q;
              rdy_q     <= 1'b1;
              if (rdy_q) begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          baud_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. A table of frames is driven serially
// at 44 clk/bit and the registered outputs are compared after each frame, then
// hand-written sequences cover latency, same-edge ack, glitch, break and reset.
module tb_uart_rx;

  localparam int CPB       = 44;
  localparam int FRAME_LEN = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  int n_vec  = 0;
  int n_miss = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .clr_rdy   (clr_rdy),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter used to time the ready latency.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: frame_err high cycles, rdy rising edges and when they happened.
  int   fe_hi     = 0;
  int   rise_cnt  = 0;
  int   last_rise = 0;
  logic rdy_prev  = 1'b0;
  always @(negedge clk) begin
    rdy_prev <= rdy;
    if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
      rise_cnt  <= rise_cnt + 1;
      last_rise <= cyc;
    end
    if (frame_err === 1'b1) fe_hi <= fe_hi + 1;
  end

  // Run-time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         clr_at;   // frame cycle at which clr_rdy pulses, -1 for none
    int         gap;      // idle-high cycles after the frame
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_ovr;
    int         exp_fe;   // frame_err high cycles during this frame
  } vec_t;

  vec_t vecs[7];
  int   t0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives len cycles of an 8N1 frame, changing inputs on negedges only.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int clr_at, input int len);
    for (int j = 0; j < len; j++) begin
      int b;
      b = j / CPB;
      if (j == 0) t0 = cyc;
      if (b == 0)      RX = 1'b0;
      else if (b <= 8) RX = data[b-1];
      else             RX = stop;
      clr_rdy = (j == clr_at);
      @(negedge clk);
    end
    clr_rdy = 1'b0;
    RX      = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int fe0;
    int r0;

    // Frame table; outputs carry from one entry to the next.
    vecs[0] = '{8'hA5, 1'b1, -1, 10, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h00, 1'b1,  0,  0, 8'h00, 1'b1, 1'b0, 0};
    vecs[2] = '{8'hFF, 1'b1,  0, 20, 8'hFF, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h5A, 1'b0,  0, 20, 8'hFF, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h3C, 1'b1, -1,  0, 8'h3C, 1'b1, 1'b0, 0};
    vecs[5] = '{8'hC3, 1'b1, -1, 10, 8'hC3, 1'b1, 1'b1, 0};
    vecs[6] = '{8'h81, 1'b1,  0, 10, 8'h81, 1'b1, 1'b0, 0};

    rst     = 1'b1;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rx_data",   32'(rx_data),   32'h00);
    check("reset rdy",       32'(rdy),       32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun",   32'(overrun),   32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      fe0 = fe_hi;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].clr_at, FRAME_LEN);
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d rdy", i),     32'(rdy),     32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d frame_err cycles", i), 32'(fe_hi - fe0), 32'(vecs[i].exp_fe));
      repeat (vecs[i].gap) @(negedge clk);
    end

    // Acknowledge clears rdy; a second ack with rdy low changes nothing.
    pulse_clr();
    check("ack rdy",     32'(rdy),     32'h0);
    check("ack overrun", 32'(overrun), 32'h0);
    pulse_clr();
    check("idle ack rdy",     32'(rdy),     32'h0);
    check("idle ack rx_data", 32'(rx_data), 32'h81);
    repeat (10) @(negedge clk);

    // Ready latency: 420 edges after the edge that first captures RX low.
    r0 = rise_cnt;
    send_frame(8'h96, 1'b1, -1, FRAME_LEN);
    check("latency rdy rises once", 32'(rise_cnt - r0), 32'd1);
    check("latency edges", 32'(last_rise - t0 - 1), 32'd420);
    check("latency rx_data", 32'(rx_data), 32'h96);
    repeat (10) @(negedge clk);

    // clr_rdy on the same edge as a good stop: the set wins, overrun flags.
    send_frame(8'h69, 1'b1, 420, FRAME_LEN);
    check("same-edge rdy",     32'(rdy),     32'h1);
    check("same-edge overrun", 32'(overrun), 32'h1);
    check("same-edge rx_data", 32'(rx_data), 32'h69);
    pulse_clr();
    check("ack after overrun rdy",     32'(rdy),     32'h0);
    check("ack after overrun overrun", 32'(overrun), 32'h0);

    // Short low glitch: rejected at mid start bit.
    fe0 = fe_hi;
    RX = 1'b0;
    repeat (10) @(negedge clk);
    RX = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch rdy",       32'(rdy),          32'h0);
    check("glitch frame_err", 32'(fe_hi - fe0),  32'd0);
    check("glitch rx_data",   32'(rx_data),      32'h69);

    // Break: line held low gives exactly one frame error cycle.
    fe0 = fe_hi;
    RX = 1'b0;
    repeat (1000) @(negedge clk);
    RX = 1'b1;
    repeat (50) @(negedge clk);
    check("break frame_err cycles", 32'(fe_hi - fe0), 32'd1);
    check("break rdy",              32'(rdy),         32'h0);
    check("break rx_data",          32'(rx_data),     32'h69);

    // Reset during data bit 4 clears outputs at once; next frame is clean.
    send_frame(8'hE7, 1'b1, -1, CPB + 4 * CPB + 10);
    rst = 1'b1;
    #1;
    check("mid-frame reset rx_data",   32'(rx_data),   32'h00);
    check("mid-frame reset rdy",       32'(rdy),       32'h0);
    check("mid-frame reset frame_err", 32'(frame_err), 32'h0);
    check("mid-frame reset overrun",   32'(overrun),   32'h0);
    repeat (3) @(negedge clk);
    RX  = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    fe0 = fe_hi;
    send_frame(8'h5A, 1'b1, -1, FRAME_LEN);
    check("post-reset rx_data",   32'(rx_data),     32'h5A);
    check("post-reset rdy",       32'(rdy),         32'h1);
    check("post-reset overrun",   32'(overrun),     32'h0);
    check("post-reset frame_err", 32'(fe_hi - fe0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
